// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants for the write-back / register file slice
//
// Purpose : status codes, register IDs, icode values and the write-back FSM
//           state type used by wb_regfile and wb_stat_ctrl.
// Ports   : none (package).
package y86_pkg;

  // Architectural status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Register IDs
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] REG_RSP = 4'd4;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Write-back commit FSM
  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_STOP = 1'b1
  } wb_state_t;

  // A destination ID requests a write unless it is RNONE
  function automatic logic is_write_id(input logic [3:0] id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/wb_stat_ctrl.sv
// rtl/wb_stat_ctrl.sv - RUN/STOP commit control and architectural status registers
//
// Purpose : decides whether the instruction in write-back may commit, latches the
//           first non-AOK status and freezes further commits until reset.
// Ports   :
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   w_stat     in   2  status of the instruction in write-back
//   commit_en  out  1  register writes allowed this cycle
//   cpu_stat   out  2  committed architectural status (registered)
//   halted     out  1  1 once a non-AOK status has committed (registered)
module wb_stat_ctrl
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] w_stat,
  output logic       commit_en,
  output logic [1:0] cpu_stat,
  output logic       halted
);

  wb_state_t state;

  // Only an AOK instruction seen while running may write the register file;
  // the faulting instruction itself never commits.
  assign commit_en = (state == WB_RUN) && (w_stat == STAT_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WB_RUN;
      cpu_stat <= STAT_AOK;
      halted   <= 1'b0;
    end else begin
      case (state)
        WB_RUN: begin
          if (w_stat != STAT_AOK) begin
            cpu_stat <= w_stat;
            halted   <= 1'b1;
            state    <= WB_STOP;
          end
        end
        WB_STOP: begin
          // Absorbing: status of the first fault is preserved until reset.
          state <= WB_STOP;
        end
        default: state <= WB_RUN;
      endcase
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - Y86-64 write-back sink: program register file with two read ports
//
// Purpose : commits valE/valM from the write-back register into the 15-entry
//           register file and serves the decode stage's srcA/srcB reads.
// Config  : define WB_REGFILE_BYPASS_EN for write-first read ports; undefined,
//           reads return the pre-edge contents.
// Ports   :
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous active-high reset
//   w_stat    in   2       status of instruction in write-back
//   w_icode   in   4       icode of instruction in write-back
//   w_valE    in   DATA_W  ALU result
//   w_valM    in   DATA_W  memory read result
//   w_dstE    in   4       destination for valE (RNONE = no write)
//   w_dstM    in   4       destination for valM (RNONE = no write)
//   d_srcA    in   4       read port A address
//   d_srcB    in   4       read port B address
//   d_rvalA   out  DATA_W  read data A (combinational)
//   d_rvalB   out  DATA_W  read data B (combinational)
//   cpu_stat  out  2       committed architectural status
//   halted    out  1       1 once any non-AOK status has committed
module wb_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                NREGS     = 15,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        w_stat,
  input  logic [3:0]        w_icode,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  input  logic [3:0]        w_dstE,
  input  logic [3:0]        w_dstM,
  input  logic [3:0]        d_srcA,
  input  logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB,
  output logic [1:0]        cpu_stat,
  output logic              halted
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              commit_en;
  logic              we_e;
  logic              we_m;

  // icode travels with the write-back bundle but no commit decision depends on it.
  logic unused_icode;
  assign unused_icode = ^w_icode;

  wb_stat_ctrl u_stat_ctrl (
    .clk       (clk),
    .rst       (rst),
    .w_stat    (w_stat),
    .commit_en (commit_en),
    .cpu_stat  (cpu_stat),
    .halted    (halted)
  );

  assign we_e = commit_en && is_write_id(w_dstE);
  assign we_m = commit_en && is_write_id(w_dstM);

  // Per-register update; valM is checked first so it wins when both ports
  // target the same register (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i[3:0] == REG_RSP) ? RSP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_m && (w_dstM == i[3:0])) begin
          regs[i] <= w_valM;
        end else if (we_e && (w_dstE == i[3:0])) begin
          regs[i] <= w_valE;
        end
      end
    end
  end

  // Read muxes. RNONE (15) matches no entry and so reads as zero; the write
  // enables already exclude RNONE, so the bypass never fires for it either.
  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (d_srcA == i[3:0]) d_rvalA = regs[i];
      if (d_srcB == i[3:0]) d_rvalB = regs[i];
    end
`ifdef WB_REGFILE_BYPASS_EN
    if (we_e && (w_dstE == d_srcA)) d_rvalA = w_valE;
    if (we_m && (w_dstM == d_srcA)) d_rvalA = w_valM;
    if (we_e && (w_dstE == d_srcB)) d_rvalB = w_valE;
    if (we_m && (w_dstM == d_srcB)) d_rvalB = w_valM;
`endif
  end

endmodule
